// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Packed-SIMD ALU. Lane width is selected at run time, and every
//             lane is computed in isolation. Results are registered with a
//             1-cycle latency, and opcodes 1011-1111 hold the previous output.
//  Revision : 1.0  initial release
// ============================================================================
module alu #(
  parameter int WIDTH          = 8,
  parameter int BITS           = 64,
  parameter int precision_bits = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BITS-1:0]           a,
  input  logic [BITS-1:0]           b,
  input  logic [precision_bits-1:0] precision,
  input  logic [3:0]                opcode,
  output logic [BITS-1:0]           result_final,
  output logic                      carry
);

  localparam logic [3:0] c_OP_AND     = 4'b0000;
  localparam logic [3:0] c_OP_OR      = 4'b0001;
  localparam logic [3:0] c_OP_XOR     = 4'b0010;
  localparam logic [3:0] c_OP_ADD     = 4'b0011;
  localparam logic [3:0] c_OP_SEQ     = 4'b0100;
  localparam logic [3:0] c_OP_SNE     = 4'b0101;
  localparam logic [3:0] c_OP_SUB     = 4'b0110;
  localparam logic [3:0] c_OP_AVG_SUB = 4'b0111;
  localparam logic [3:0] c_OP_AVG_ADD = 4'b1000;
  localparam logic [3:0] c_OP_MAX     = 4'b1001;
  localparam logic [3:0] c_OP_MIN     = 4'b1010;

  localparam int c_NPREC = 1 << precision_bits;

  logic [c_NPREC-1:0][BITS-1:0] w_lane_res;
  logic [c_NPREC-1:0]           w_lane_cy;

  logic [BITS-1:0] r_result;
  logic            r_carry;
  logic [BITS-1:0] w_next_res;
  logic            w_next_cy;
  logic            w_load;

  // One full lane datapath per precision setting. The precision mux below
  // selects among them, so no carry or compare path ever crosses a lane edge.
  for (genvar p = 0; p < c_NPREC; p++) begin : g_prec
    localparam int c_LW_RAW = WIDTH << p;
    localparam int c_LW     = (c_LW_RAW > BITS) ? BITS : c_LW_RAW;
    localparam int c_NLANE  = BITS / c_LW;

    for (genvar l = 0; l < c_NLANE; l++) begin : g_lane
      logic [c_LW-1:0] w_la;
      logic [c_LW-1:0] w_lb;
      logic [c_LW-1:0] w_sum;
      logic [c_LW-1:0] w_diff;
      logic [c_LW-1:0] w_out;
      logic            w_a_ge;
      logic            w_a_le;

      assign w_la   = a[l*c_LW +: c_LW];
      assign w_lb   = b[l*c_LW +: c_LW];
      assign w_sum  = w_la + w_lb;
      assign w_diff = w_la - w_lb;
      assign w_a_ge = $signed(w_la) >= $signed(w_lb);
      assign w_a_le = $signed(w_la) <= $signed(w_lb);

      always_comb begin
        w_out = '0;
        case (opcode)
          c_OP_ADD:     w_out = w_sum;
          c_OP_SUB:     w_out = w_diff;
          c_OP_SEQ:     w_out = c_LW'(w_la == w_lb);
          c_OP_SNE:     w_out = c_LW'(w_la != w_lb);
          c_OP_AVG_ADD: w_out = {1'b0, w_sum[c_LW-1:1]};
          c_OP_AVG_SUB: w_out = {1'b0, w_diff[c_LW-1:1]};
          c_OP_MAX:     w_out = w_a_ge ? w_la : w_lb;
          c_OP_MIN:     w_out = w_a_le ? w_la : w_lb;
          default:      w_out = '0;
        endcase
      end

      assign w_lane_res[p][l*c_LW +: c_LW] = w_out;

      // Carry-out is recovered from the operand MSBs and the truncated sum
      // MSB, which avoids building a wider adder just for one bit.
      if (l == c_NLANE - 1) begin : g_msb
        assign w_lane_cy[p] = (w_la[c_LW-1] & w_lb[c_LW-1]) |
                              ((w_la[c_LW-1] ^ w_lb[c_LW-1]) & ~w_sum[c_LW-1]);
      end
    end
  end

  always_comb begin
    w_load     = 1'b1;
    w_next_res = r_result;
    w_next_cy  = 1'b0;
    case (opcode)
      c_OP_AND: w_next_res = a & b;
      c_OP_OR:  w_next_res = a | b;
      c_OP_XOR: w_next_res = a ^ b;
      c_OP_ADD, c_OP_AVG_ADD: begin
        w_next_res = w_lane_res[precision];
        w_next_cy  = w_lane_cy[precision];
      end
      c_OP_SUB, c_OP_SEQ, c_OP_SNE, c_OP_AVG_SUB, c_OP_MAX, c_OP_MIN:
        w_next_res = w_lane_res[precision];
      default: begin
        w_load    = 1'b0;
        w_next_cy = r_carry;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (w_load) begin
      r_result <= w_next_res;
      r_carry  <= w_next_cy;
    end
  end

  assign result_final = r_result;
  assign carry        = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Scoreboard bench for alu. It applies directed vectors with
//             hand-computed results, then random vectors checked against a
//             per-lane reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  precision;
  logic [3:0]  opcode;
  logic [63:0] result_final;
  logic        carry;

  logic [64:0] sb_q[$];
  logic [64:0] m_state;
  int          n_vec;
  int          n_err;

  alu #(.WIDTH(8), .BITS(64), .precision_bits(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .precision    (precision),
    .opcode       (opcode),
    .result_final (result_final),
    .carry        (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The monitor checks the registered output 1 time unit after each edge.
  always @(posedge clk) begin
    logic [64:0] exp_v;
    #1;
    if (sb_q.size() != 0) begin
      exp_v = sb_q.pop_front();
      n_vec++;
      if (result_final !== exp_v[63:0] || carry !== exp_v[64]) begin
        n_err++;
        $display("FAIL vec%0d: got result=%h carry=%b, want result=%h carry=%b",
                 n_vec, result_final, carry, exp_v[63:0], exp_v[64]);
      end
    end
  end

  // Independent lane model. Signed ordering uses the sign-bit-flip trick.
  function automatic logic [64:0] model(input logic [63:0] fa, input logic [63:0] fb,
                                        input logic [1:0] fp, input logic [3:0] fo,
                                        input logic [64:0] prev);
    int          lw;
    int          n;
    logic [64:0] mask;
    logic [64:0] sbit;
    logic [64:0] la;
    logic [64:0] lb;
    logic [64:0] s;
    logic [64:0] d;
    logic [64:0] lr;
    logic [64:0] acc;
    logic        c;
    if (fo >= 4'b1011) return prev;
    if (fo == 4'b0000) return {1'b0, fa & fb};
    if (fo == 4'b0001) return {1'b0, fa | fb};
    if (fo == 4'b0010) return {1'b0, fa ^ fb};
    lw   = 8 << fp;
    n    = 64 / lw;
    mask = (65'd1 << lw) - 65'd1;
    sbit = 65'd1 << (lw - 1);
    acc  = '0;
    c    = 1'b0;
    for (int i = 0; i < n; i++) begin
      la = ({1'b0, fa} >> (i * lw)) & mask;
      lb = ({1'b0, fb} >> (i * lw)) & mask;
      s  = la + lb;
      d  = (la - lb) & mask;
      lr = '0;
      case (fo)
        4'b0011: lr = s & mask;
        4'b0110: lr = d;
        4'b0100: lr = (la == lb) ? 65'd1 : 65'd0;
        4'b0101: lr = (la != lb) ? 65'd1 : 65'd0;
        4'b1000: lr = (s & mask) >> 1;
        4'b0111: lr = d >> 1;
        4'b1001: lr = ((la ^ sbit) >= (lb ^ sbit)) ? la : lb;
        4'b1010: lr = ((la ^ sbit) <= (lb ^ sbit)) ? la : lb;
        default: lr = '0;
      endcase
      if (i == n - 1 && (fo == 4'b0011 || fo == 4'b1000)) c = s[lw];
      acc = acc | (lr << (i * lw));
    end
    return {c, acc[63:0]};
  endfunction

  task automatic drive(input logic r, input logic [63:0] va, input logic [63:0] vb,
                       input logic [1:0] vp, input logic [3:0] vo,
                       input logic [63:0] er, input logic ec);
    @(negedge clk);
    rst       = r;
    a         = va;
    b         = vb;
    precision = vp;
    opcode    = vo;
    sb_q.push_back({ec, er});
    m_state = {ec, er};
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; a = '0; b = '0; precision = '0; opcode = '0;
    m_state = '0;

    drive(1, 64'h0, 64'h0, 2'b00, 4'b0011, 64'h0, 1'b0);
    drive(0, 64'hFF, 64'h1, 2'b00, 4'b0011, 64'h0, 1'b0);
    drive(0, 64'hFF, 64'h1, 2'b11, 4'b0011, 64'h100, 1'b0);
    drive(0, 64'h1234000056789ABC, 64'h1234FFFF56780000, 2'b01, 4'b0100,
          64'h0001000000010000, 1'b0);
    drive(0, 64'h80, 64'h7F, 2'b00, 4'b1001, 64'h7F, 1'b0);
    drive(0, 64'h80, 64'h7F, 2'b00, 4'b1010, 64'h80, 1'b0);
    drive(0, 64'hFF, 64'h03, 2'b00, 4'b1000, 64'h1, 1'b0);
    drive(0, 64'h1, 64'h2, 2'b10, 4'b0111, 64'h7FFFFFFF, 1'b0);
    drive(0, 64'hFF00000000000000, 64'h0100000000000000, 2'b00, 4'b0011, 64'h0, 1'b1);
    drive(0, 64'h1234, 64'h5678, 2'b00, 4'b1100, 64'h0, 1'b1);
    drive(0, 64'h0, 64'h1, 2'b01, 4'b0110, 64'h000000000000FFFF, 1'b0);
    drive(0, 64'h0000000100000000, 64'h0, 2'b10, 4'b0101, 64'h0000000100000000, 1'b0);
    drive(0, 64'h0F0F, 64'hF000, 2'b00, 4'b0001, 64'hFF0F, 1'b0);
    drive(0, 64'h8000, 64'h0001, 2'b01, 4'b1001, 64'h0001, 1'b0);
    drive(0, 64'hF0, 64'h0F, 2'b00, 4'b0010, 64'hFF, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(0, 64'hDEADBEEF, 64'h12345678, 2'(i), 4'b1111, 64'hFF, 1'b0);
    drive(1, 64'hDEADBEEF, 64'h12345678, 2'b00, 4'b1111, 64'h0, 1'b0);
    drive(0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 2'b11, 4'b1000, 64'h0, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic [1:0]  rp;
      logic [3:0]  ro;
      logic [64:0] e;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      rp = 2'($urandom_range(0, 3));
      ro = 4'($urandom_range(0, 15));
      e  = model(ra, rb, rp, ro, m_state);
      drive(0, ra, rb, rp, ro, e[63:0], e[64]);
    end

    begin
      int guard;
      guard = 0;
      while (sb_q.size() != 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (sb_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
